// File: rtl/env_int_pkg.sv
// rtl/env_int_pkg.sv - shared constants, FSM state type and priority encoder for env_int_ctl
//
// Purpose: register offsets within the I/O window, the interrupt FSM state
// enum, and a lowest-index-wins priority encoder used for both candidate
// selection and EOI clearing.
package env_int_pkg;

  localparam logic [2:0] OFS_MASK = 3'd0;
  localparam logic [2:0] OFS_PEND = 3'd1;
  localparam logic [2:0] OFS_SEL  = 3'd2;
  localparam logic [2:0] OFS_CNT  = 3'd3;
  localparam logic [2:0] OFS_VEC  = 3'd4;
  localparam logic [2:0] OFS_EOI  = 3'd5;

  typedef enum logic [1:0] {IDLE, ASSERT, ACK, SERVICE} state_e;

  // Returns {found, index}; index 0 has the highest priority.
  function automatic logic [3:0] prio_enc(input logic [7:0] v);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/env_int_timer.sv
// rtl/env_int_timer.sv - single 8-bit interrupt countdown timer
//
// Purpose: counts a loaded value down to zero, one step per clock, and
// pulses expire_o on the 1->0 step. A load (including a load of 0, which
// cancels) takes priority over the decrement and never expires.
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset
//   load_i          load load_val_i this clock
//   load_val_i      value to load
//   count_o         current count
//   expire_o        combinational pulse on the clock that steps 1->0
module env_int_timer (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] count_o,
  output logic       expire_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_d    = cnt_q - 8'd1;
      expire_o = (cnt_q == 8'd1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/env_int_ctl.sv
// rtl/env_int_ctl.sv - Z80 I/O-mapped interrupt controller for the tv80 bench
//
// Purpose: collects timer and external interrupt sources, drives int_n for
// the highest-priority enabled pending source, supplies a mode-2 vector in
// the acknowledge cycle and tracks in-service state until EOI.
// Optional macro ENV_INT_NEST_EN: allows a higher-priority source to preempt
// while another is in service.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   iorq_n, rd_n, wr_n, m1_n    Z80 bus strobes (active low)
//   addr, D_OUT                 I/O address low byte, CPU write data
//   di_out, di_oe               read/vector data and its drive enable
//   ext_req                     external level requests (rising edge = event)
//   int_n                       maskable interrupt to CPU (active low)
//   in_service                  in-service bits for the bench monitor
module env_int_ctl
  import env_int_pkg::*;
#(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter logic [7:0] VEC_RST   = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iorq_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic               m1_n,
  input  logic [7:0]         addr,
  input  logic [7:0]         D_OUT,
  output logic [7:0]         di_out,
  output logic               di_oe,
  input  logic [NUM_SRC-1:0] ext_req,
  output logic               int_n,
  output logic [NUM_SRC-1:0] in_service
);

  logic               wr_stb, wr_stb_q, wr_fire, wr_hit;
  logic [7:0]         wr_addr_q, wr_data_q, rd_data;
  logic [8:0]         wofs, rofs;
  logic               wr_mask, wr_pend, wr_sel, wr_cnt, wr_vec, wr_eoi;
  logic [NUM_SRC-1:0] mask_q, pend_q, pend_d, ext_q, in_svc_q, in_svc_d;
  logic [NUM_SRC-1:0] expire, src_oh;
  logic [2:0]         sel_q, src_q, src_d;
  logic [7:0]         vec_q, cand_vec8, svc_vec8;
  logic [3:0]         cand_enc, svc_enc;
  logic [7:0]         cnt [NUM_SRC];
  logic               int_n_q, int_n_d, ack_bus, ack_done, vec_drive, rd_hit;
  state_e             state_q, state_d;

  // Writes act once, on the clock after the strobe drops; address and data
  // are captured while the strobe is high so late bus changes do not matter.
  assign wr_stb  = !iorq_n && !wr_n && m1_n;
  assign wr_fire = wr_stb_q && !wr_stb;
  // 9-bit offsets: an address below the base wraps far above 5.
  assign wofs    = {1'b0, wr_addr_q} - {1'b0, BASE_ADDR};
  assign rofs    = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign wr_hit  = wr_fire && (wofs <= 9'd5);
  assign wr_mask = wr_hit && (wofs[2:0] == OFS_MASK);
  assign wr_pend = wr_hit && (wofs[2:0] == OFS_PEND);
  assign wr_sel  = wr_hit && (wofs[2:0] == OFS_SEL);
  assign wr_cnt  = wr_hit && (wofs[2:0] == OFS_CNT);
  assign wr_vec  = wr_hit && (wofs[2:0] == OFS_VEC);
  assign wr_eoi  = wr_hit && (wofs[2:0] == OFS_EOI);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_tmr
    env_int_timer u_tmr (
      .clk_i      (clk),
      .reset_i    (reset),
      .load_i     (wr_cnt && (sel_q == 3'(g))),
      .load_val_i (wr_data_q),
      .count_o    (cnt[g]),
      .expire_o   (expire[g])
    );
  end

  always_comb begin
    cand_vec8 = 8'h00;
    svc_vec8  = 8'h00;
    cand_vec8[NUM_SRC-1:0] = pend_q & mask_q;
    svc_vec8[NUM_SRC-1:0]  = in_svc_q;
    cand_enc = prio_enc(cand_vec8);
    svc_enc  = prio_enc(svc_vec8);
    src_oh   = '0;
    for (int i = 0; i < NUM_SRC; i++) src_oh[i] = (src_q == 3'(i));
  end

  assign ack_bus = !m1_n && !iorq_n;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    int_n_d  = int_n_q;
    ack_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (cand_enc[3] && (in_svc_q == '0)) begin
          src_d   = cand_enc[2:0];
          int_n_d = 1'b0;
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        // Acknowledge wins over a same-cycle withdrawal so the CPU never
        // reads an undriven vector.
        if (ack_bus) begin
          state_d = ACK;
        end else if (!cand_vec8[src_q]) begin
          int_n_d = 1'b1;
          state_d = (in_svc_q == '0) ? IDLE : SERVICE;
        end
      end
      ACK: begin
        if (iorq_n) begin
          ack_done = 1'b1;
          int_n_d  = 1'b1;
          state_d  = SERVICE;
        end
      end
      SERVICE: begin
        if (in_svc_q == '0) begin
          state_d = IDLE;
        end
`ifdef ENV_INT_NEST_EN
        else if (cand_enc[3] && (cand_enc[2:0] < svc_enc[2:0])) begin
          src_d   = cand_enc[2:0];
          int_n_d = 1'b0;
          state_d = ASSERT;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // New events are OR-ed in last so a same-cycle set beats any clear.
  always_comb begin
    pend_d = pend_q;
    if (wr_pend)  pend_d = pend_d & ~wr_data_q[NUM_SRC-1:0];
    if (ack_done) pend_d = pend_d & ~src_oh;
    pend_d = pend_d | expire | (ext_req & ~ext_q);

    in_svc_d = in_svc_q;
    if (wr_eoi && svc_enc[3]) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (svc_enc[2:0] == 3'(i)) in_svc_d[i] = 1'b0;
      end
    end
    if (ack_done) in_svc_d = in_svc_d | src_oh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
      ext_q     <= '0;
      mask_q    <= '0;
      pend_q    <= '0;
      in_svc_q  <= '0;
      sel_q     <= 3'd0;
      vec_q     <= VEC_RST;
      src_q     <= 3'd0;
      int_n_q   <= 1'b1;
      state_q   <= IDLE;
    end else begin
      wr_stb_q <= wr_stb;
      if (wr_stb) begin
        wr_addr_q <= addr;
        wr_data_q <= D_OUT;
      end
      ext_q    <= ext_req;
      if (wr_mask) mask_q <= wr_data_q[NUM_SRC-1:0];
      if (wr_sel)  sel_q  <= wr_data_q[2:0];
      if (wr_vec)  vec_q  <= {wr_data_q[7:1], 1'b0};
      pend_q   <= pend_d;
      in_svc_q <= in_svc_d;
      src_q    <= src_d;
      int_n_q  <= int_n_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (rofs[2:0])
      OFS_MASK: rd_data[NUM_SRC-1:0] = mask_q;
      OFS_PEND: rd_data[NUM_SRC-1:0] = pend_q;
      OFS_SEL:  rd_data[2:0] = sel_q;
      OFS_CNT: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (sel_q == 3'(i)) rd_data = cnt[i];
        end
      end
      OFS_VEC:  rd_data = vec_q;
      default:  rd_data = 8'h00;
    endcase
  end

  // Drive enables are combinational and gated by reset so the bus is
  // released in the very cycle reset is applied.
  assign rd_hit    = !iorq_n && !rd_n && (rofs <= 9'd5);
  assign vec_drive = (state_q == ACK) && ack_bus;
  assign di_oe     = !reset && (rd_hit || vec_drive);
  assign di_out    = !di_oe ? 8'h00 :
                     vec_drive ? (vec_q | {4'b0000, src_q, 1'b0}) : rd_data;

  assign int_n      = int_n_q;
  assign in_service = in_svc_q;

endmodule
